// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction prefetch front-end.
// Holds the fetch FSM encoding, default geometry and the buffered entry layout.
package fetch_pkg;

    localparam int          DEPTH_DEFAULT    = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0013;

    localparam logic [0:0] ST_FETCH   = 1'b0;
    localparam logic [0:0] ST_DISCARD = 1'b1;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; count, full and empty are registered.
// The head word is read combinationally so a push is visible on the next cycle.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             full_reg, empty_reg;
    logic             do_push, do_pop;

    assign do_push = push && !full_reg;
    assign do_pop  = pop && !empty_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_push) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
            if (do_push && !do_pop)      count_next = count_reg + 1'b1;
            else if (do_pop && !do_push) count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            full_reg   <= (count_next == FULL_COUNT);
            empty_reg  <= (count_next == '0);
        end
    end

    // Storage needs no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_reg[wr_ptr_reg] <= wdata;
    end

    assign rdata = mem_reg[rd_ptr_reg];
    assign count = count_reg;
    assign full  = full_reg;
    assign empty = empty_reg;

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: issues word reads on the native bus and
// queues {instruction, pc} pairs for decode; redirects flush and restart fetch.
module instr_prefetch_buffer
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = DEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_wstrb,
    input  logic [31:0]              mem_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instr_data,
    output logic [31:0]              instr_pc,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    logic [0:0]   state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  hold_addr_reg, hold_addr_next;

    logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
    fetch_entry_t push_entry, head_entry;
    logic [63:0]  head_bits;

    // Issue only with a guaranteed free slot; in DISCARD the old request is held.
    assign mem_valid = !rst && ((state_reg == ST_DISCARD) || !fifo_full);
    assign mem_addr  = (state_reg == ST_DISCARD) ? hold_addr_reg : pc_reg;
    assign mem_wdata = '0;
    assign mem_wstrb = '0;

    assign fifo_push  = (state_reg == ST_FETCH) && mem_valid && mem_ready && !redirect_valid;
    assign fifo_pop   = instr_valid && instr_ready && !redirect_valid;
    assign push_entry = '{data: mem_rdata, pc: pc_reg};

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .srst  (rst),
        .push  (fifo_push),
        .wdata (push_entry),
        .pop   (fifo_pop),
        .flush (redirect_valid),
        .rdata (head_bits),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_entry  = fetch_entry_t'(head_bits);
    assign instr_valid = !fifo_empty;
    assign instr_data  = fifo_empty ? 32'h0 : head_entry.data;
    assign instr_pc    = fifo_empty ? 32'h0 : head_entry.pc;

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        hold_addr_next = hold_addr_reg;
        case (state_reg)
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_next = word_align(redirect_pc);
                    if (mem_valid && !mem_ready) begin
                        state_next     = ST_DISCARD;
                        hold_addr_next = pc_reg;
                    end
                end else if (mem_valid && mem_ready) begin
                    pc_next = pc_reg + 32'd4;
                end
            end
            ST_DISCARD: begin
                // The held beat is dropped; a late redirect only retargets pc.
                if (redirect_valid) pc_next = word_align(redirect_pc);
                if (mem_ready)      state_next = ST_FETCH;
            end
            default: state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_FETCH;
            pc_reg        <= RESET_PC;
            hold_addr_reg <= RESET_PC;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            hold_addr_reg <= hold_addr_next;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer: vector table plus redirect/reset sequences.
// A small ROM model with programmable wait states sits on the memory bus.
module tb_instr_prefetch_buffer;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_fail   = 0;
    int ws       = 0;
    int wait_cnt = 0;

    instr_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h8000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_rdata      (mem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fifo_count     (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h8000_0000: return 32'h8000_8137;
            32'h8000_0004: return 32'h0001_0113;
            32'h8000_00BC: return 32'h8000_12b7;
            32'h8000_00C8: return 32'h8000_22b7;
            default:       return a ^ 32'h5A5A_0013;
        endcase
    endfunction

    always_comb mem_rdata = rom(mem_addr);
    always_comb mem_ready = mem_valid && (wait_cnt >= ws);

    always @(posedge clk) begin
        if (mem_valid && !mem_ready) wait_cnt <= wait_cnt + 1;
        else                         wait_cnt <= 0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        mv;
        logic [31:0] ma;
        logic        iv;
        logic [31:0] id;
        logic [31:0] ipc;
        int          cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                                input logic mv, input logic [31:0] ma, input logic iv,
                                input logic [31:0] id, input logic [31:0] ipc, input int cnt);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.mv = mv; v.ma = ma; v.iv = iv; v.id = id; v.ipc = ipc; v.cnt = cnt;
        return v;
    endfunction

    vec_t vecs [16];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        // Reset/streaming, fill to full, single pop, redirect with a full FIFO.
        vecs[0]  = mk(1, 1, 0, 0, 0, 32'h8000_0000, 0, 32'h0, 32'h0, 0);
        vecs[1]  = mk(0, 1, 0, 0, 1, 32'h8000_0000, 0, 32'h0, 32'h0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 1, 32'h8000_0004, 1, 32'h8000_8137, 32'h8000_0000, 1);
        vecs[3]  = mk(0, 1, 0, 0, 1, 32'h8000_0008, 1, 32'h0001_0113, 32'h8000_0004, 1);
        vecs[4]  = mk(1, 0, 0, 0, 0, 32'h8000_000C, 1, rom(32'h8000_0008), 32'h8000_0008, 1);
        vecs[5]  = mk(0, 0, 0, 0, 1, 32'h8000_0000, 0, 32'h0, 32'h0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 1, 32'h8000_0004, 1, 32'h8000_8137, 32'h8000_0000, 1);
        vecs[7]  = mk(0, 0, 0, 0, 1, 32'h8000_0008, 1, 32'h8000_8137, 32'h8000_0000, 2);
        vecs[8]  = mk(0, 0, 0, 0, 1, 32'h8000_000C, 1, 32'h8000_8137, 32'h8000_0000, 3);
        vecs[9]  = mk(0, 0, 0, 0, 0, 32'h8000_0010, 1, 32'h8000_8137, 32'h8000_0000, 4);
        vecs[10] = mk(0, 1, 0, 0, 0, 32'h8000_0010, 1, 32'h8000_8137, 32'h8000_0000, 4);
        vecs[11] = mk(0, 0, 0, 0, 1, 32'h8000_0010, 1, 32'h0001_0113, 32'h8000_0004, 3);
        vecs[12] = mk(0, 0, 0, 0, 0, 32'h8000_0014, 1, 32'h0001_0113, 32'h8000_0004, 4);
        vecs[13] = mk(0, 0, 1, 32'h8000_00BE, 0, 32'h8000_0014, 1, 32'h0001_0113, 32'h8000_0004, 4);
        vecs[14] = mk(0, 1, 0, 0, 1, 32'h8000_00BC, 0, 32'h0, 32'h0, 0);
        vecs[15] = mk(0, 1, 0, 0, 1, 32'h8000_00C0, 1, 32'h8000_12b7, 32'h8000_00BC, 1);

        rst = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; ws = 0;
        #1;
        for (int i = 0; i < 16; i++) begin
            rst = vecs[i].rst; instr_ready = vecs[i].rdy;
            redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
            @(negedge clk);
            check($sformatf("v%0d mem_valid", i), 32'(mem_valid), 32'(vecs[i].mv));
            check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].ma);
            check($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].iv));
            check($sformatf("v%0d instr_data", i), instr_data, vecs[i].id);
            check($sformatf("v%0d instr_pc", i), instr_pc, vecs[i].ipc);
            check($sformatf("v%0d fifo_count", i), 32'(fifo_count), 32'(vecs[i].cnt));
            $display("vec %0d: mem_valid=%b addr=%h instr_valid=%b pc=%h count=%0d",
                     i, mem_valid, mem_addr, instr_valid, instr_pc, fifo_count);
            step();
        end
        check("wdata_wstrb", {mem_wdata[27:0], mem_wstrb}, 32'h0);

        // Redirect during a wait-stated request: bus held, beat dropped.
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0020;
        step();
        redirect_valid = 1'b0; ws = 3;
        #1;
        check("t4 first addr", mem_addr, 32'h8000_0020);
        check("t4 waiting", 32'(mem_ready), 32'h0);
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_00C8;
        @(negedge clk);
        check("t4 hold0 addr", mem_addr, 32'h8000_0020);
        step();
        redirect_valid = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            check($sformatf("t4 hold%0d valid", k), 32'(mem_valid), 32'h1);
            check($sformatf("t4 hold%0d addr", k), mem_addr, 32'h8000_0020);
            check($sformatf("t4 hold%0d iv", k), 32'(instr_valid), 32'h0);
            step();
        end
        check("t4 new addr", mem_addr, 32'h8000_00C8);
        seen = 0;
        for (int k = 0; k < 16 && !seen; k++) begin
            @(negedge clk);
            if (instr_valid) begin
                seen = 1;
                check("t4 head pc", instr_pc, 32'h8000_00C8);
                check("t4 head data", instr_data, 32'h8000_22b7);
            end
            step();
        end
        check("t4 head arrived", 32'(seen), 32'h1);
        $display("seq redirect-during-wait done");

        // Redirect, mem_ready and instr_ready in one cycle.
        ws = 0; rst = 1'b1; step(); rst = 1'b0; instr_ready = 1'b1;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        @(negedge clk);
        check("t5 ready", 32'(mem_ready), 32'h1);
        check("t5 iv before", 32'(instr_valid), 32'h1);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t5 count", 32'(fifo_count), 32'h0);
        check("t5 iv", 32'(instr_valid), 32'h0);
        check("t5 addr", mem_addr, 32'h8000_0100);
        step();
        check("t5 head pc", instr_pc, 32'h8000_0100);
        check("t5 head data", instr_data, rom(32'h8000_0100));
        $display("seq redirect-ready-pop done");

        // Reset with three entries queued and a request pending.
        rst = 1'b1; step(); rst = 1'b0; instr_ready = 1'b0;
        step(); step(); step();
        ws = 5;
        @(negedge clk);
        check("t6 count3", 32'(fifo_count), 32'h3);
        check("t6 pending", {30'h0, mem_valid, mem_ready}, 32'h2);
        rst = 1'b1;
        step();
        @(negedge clk);
        check("t6 mv", 32'(mem_valid), 32'h0);
        check("t6 addr", mem_addr, 32'h8000_0000);
        check("t6 iv", 32'(instr_valid), 32'h0);
        check("t6 data", instr_data, 32'h0);
        check("t6 pc", instr_pc, 32'h0);
        check("t6 count", 32'(fifo_count), 32'h0);
        step();
        rst = 1'b0; ws = 0;
        #1;
        check("t6 restart", {31'h0, mem_valid} ^ mem_addr, 32'h8000_0001);
        step();
        check("t6 first instr", instr_data, 32'h8000_8137);
        $display("seq reset-mid-op done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
